// File: rtl/hero_write_rx.sv
// hero_write_rx
//   Receives a beat stream qualified by in_clk_en and in_cycle_type. Every
//   VALID or DONE beat is tagged with its index inside the transaction and a
//   last flag, and is then buffered in a DEPTH-entry FIFO for the consumer.
//
// Ports
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_cycle_type [1:0]  : 0=IDLE, 1=VALID, 2=DONE, 3=illegal
//   in_wdat [35:0]       : beat data
//   in_sub [4:0]         : opaque sideband, stored with the beat
//   in_clk_en            : beat qualifier; the cycle is ignored when 0
//   in_stall             : registered backpressure hint (occupancy >= DEPTH-2)
//   out_valid/out_ready  : output handshake
//   out_data/out_sub/out_last/out_beat_idx : head-of-FIFO beat
//   out_count            : FIFO occupancy, 0..DEPTH
//   err_overflow/err_proto/err_clr : sticky error flags and their clear
//   dbg_state            : current FSM state (0=IDLE, 1=IN_TXN)
//
// Handshake: a beat leaves the FIFO on a rising edge where out_valid and
// out_ready are both 1. out_valid never depends on out_ready, and the
// out_* fields hold steady while out_valid=1 and out_ready=0.
module hero_write_rx #(
   parameter int DEPTH     = 8,
   parameter int MAX_BEATS = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [1:0]               in_cycle_type,
   input  logic [35:0]              in_wdat,
   input  logic [4:0]               in_sub,
   input  logic                     in_clk_en,
   output logic                     in_stall,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [35:0]              out_data,
   output logic [4:0]               out_sub,
   output logic                     out_last,
   output logic [7:0]               out_beat_idx,
   output logic [$clog2(DEPTH):0]   out_count,
   output logic                     err_overflow,
   output logic                     err_proto,
   input  logic                     err_clr,
   output logic                     dbg_state
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = 1 + 8 + 5 + 36;

   localparam logic [1:0] CT_VALID = 2'd1;
   localparam logic [1:0] CT_DONE  = 2'd2;
   localparam logic [1:0] CT_ILL   = 2'd3;

   typedef enum logic {ST_IDLE = 1'b0, ST_IN_TXN = 1'b1} state_t;

   state_t            r_state;
   logic [7:0]        r_beat_cnt;
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [CW-1:0]     r_count;
   logic              r_stall;
   logic              r_err_ovf;
   logic              r_err_proto;
   logic [EW-1:0]     r_mem [DEPTH];

   logic              w_beat;
   logic              w_illegal;
   logic              w_full;
   logic              w_push;
   logic              w_pop;
   logic              w_last;
   logic [7:0]        w_idx;
   logic              w_trunc;
   state_t            w_state_nxt;
   logic [7:0]        w_cnt_nxt;
   logic [CW-1:0]     w_count_nxt;
   logic [EW-1:0]     w_head;

   assign w_beat    = in_clk_en && (in_cycle_type == CT_VALID || in_cycle_type == CT_DONE);
   assign w_illegal = in_clk_en && (in_cycle_type == CT_ILL);
   assign w_full    = (r_count == CW'(DEPTH));
   // Full is judged on the registered count only, so a pop in the same cycle
   // never makes room for a push (no path from out_ready to acceptance).
   assign w_push    = w_beat && !w_full;
   assign w_pop     = (r_count != '0) && out_ready;

   // Beat tagging and next-state logic. A dropped beat (FIFO full) still
   // advances the FSM and the beat counter.
   always_comb begin
      w_idx       = r_beat_cnt;
      w_last      = 1'b0;
      w_trunc     = 1'b0;
      w_state_nxt = r_state;
      w_cnt_nxt   = r_beat_cnt;
      if (w_beat) begin
         if (r_state == ST_IDLE) begin
            w_idx = 8'd0;
            if (in_cycle_type == CT_DONE) begin
               w_last = 1'b1;
            end else begin
               w_state_nxt = ST_IN_TXN;
               w_cnt_nxt   = 8'd1;
            end
         end else if (in_cycle_type == CT_DONE) begin
            w_last      = 1'b1;
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 8'd0;
         end else if (r_beat_cnt == 8'(MAX_BEATS - 1)) begin
            // Transaction reached its length limit: close it here.
            w_last      = 1'b1;
            w_trunc     = 1'b1;
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 8'd0;
         end else begin
            w_cnt_nxt = r_beat_cnt + 8'd1;
         end
      end
   end

   always_comb begin
      w_count_nxt = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + CW'(1);
         2'b01:   w_count_nxt = r_count - CW'(1);
         default: w_count_nxt = r_count;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_beat_cnt  <= 8'd0;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_stall     <= 1'b0;
         r_err_ovf   <= 1'b0;
         r_err_proto <= 1'b0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_beat_cnt <= w_cnt_nxt;
         r_count    <= w_count_nxt;
         r_stall    <= (w_count_nxt >= CW'(DEPTH - 2));
         if (w_push) begin
            r_mem[r_wr_ptr] <= {w_last, w_idx, in_sub, in_wdat};
            r_wr_ptr        <= r_wr_ptr + AW'(1);
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
         // Set beats clear when both happen in the same cycle.
         if (w_beat && w_full)       r_err_ovf <= 1'b1;
         else if (err_clr)           r_err_ovf <= 1'b0;
         if (w_trunc || w_illegal)   r_err_proto <= 1'b1;
         else if (err_clr)           r_err_proto <= 1'b0;
      end
   end

   assign w_head       = r_mem[r_rd_ptr];
   assign out_data     = w_head[35:0];
   assign out_sub      = w_head[40:36];
   assign out_beat_idx = w_head[48:41];
   assign out_last     = w_head[49];
   assign out_valid    = (r_count != '0);
   assign out_count    = r_count;
   assign in_stall     = r_stall;
   assign err_overflow = r_err_ovf;
   assign err_proto    = r_err_proto;
   assign dbg_state    = r_state;

endmodule
